exc_ctrl: RTL and testbench

Exception arbitration and pipeline-redirect unit, placed between the MEM stage and the CP0 register block. It observes the instruction retiring from MEM together with the current CP0 Status/Cause/EPC values, forwarded from any pending WB-stage CP0 write. It selects at most one exception (or ERET) per cycle and issues a registered flush/redirect to the pipeline. It also issues a one-cycle CP0 update strobe that carries the EPC, BD and ExcCode values.

---
 rtl/exc_ctrl_pkg.sv | 30 +++
 rtl/exc_ctrl_if.sv | 46 ++++
 rtl/exc_ctrl_fwd.sv | 32 +++
 rtl/exc_ctrl.sv | 141 ++++++++++++++
 tb/tb_exc_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception controller: ExcCodes, CP0 register
// addresses, Status bit positions and the FSM state type.
package exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;
    localparam logic [4:0] EXC_TR  = 5'd13;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int unsigned ST_IE    = 0;
    localparam int unsigned ST_EXL   = 1;
    localparam int unsigned ST_IM_LO = 8;
    localparam int unsigned ST_IM_HI = 15;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } exc_state_e;

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic in_ds);
        return in_ds ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// MEM-stage / CP0 / WB-forwarding inputs and redirect/strobe outputs of exc_ctrl.
interface exc_ctrl_if;

    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic        mem_syscall_i;
    logic        mem_ri_i;
    logic        mem_ov_i;
    logic        mem_trap_i;
    logic        mem_eret_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_wdata_i;

    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;
    logic        exc_we_o;
    logic        exc_eret_o;
    logic [4:0]  exc_code_o;
    logic        exc_bd_o;
    logic [31:0] exc_epc_o;

    modport master (
        output mem_valid_i, mem_pc_i, mem_in_delayslot_i,
               mem_syscall_i, mem_ri_i, mem_ov_i, mem_trap_i, mem_eret_i,
               cp0_status_i, cp0_cause_i, cp0_epc_i,
               wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
        input  flush_o, new_pc_o, busy_o, exc_we_o, exc_eret_o,
               exc_code_o, exc_bd_o, exc_epc_o
    );

    modport slave (
        input  mem_valid_i, mem_pc_i, mem_in_delayslot_i,
               mem_syscall_i, mem_ri_i, mem_ov_i, mem_trap_i, mem_eret_i,
               cp0_status_i, cp0_cause_i, cp0_epc_i,
               wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
        output flush_o, new_pc_o, busy_o, exc_we_o, exc_eret_o,
               exc_code_o, exc_bd_o, exc_epc_o
    );

endinterface

// File: rtl/exc_ctrl_fwd.sv
// exc_fwd: combinational CP0 forwarding of a pending WB write onto the
// Status/Cause/EPC values seen by the exception logic.
module exc_fwd
    import exc_ctrl_pkg::*;
(
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_wdata_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    output logic [31:0] status_eff_o,
    output logic [31:0] cause_eff_o,
    output logic [31:0] epc_eff_o
);

    always_comb begin
        status_eff_o = cp0_status_i;
        cause_eff_o  = cp0_cause_i;
        epc_eff_o    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            unique case (wb_cp0_waddr_i)
                CP0_STATUS: status_eff_o = wb_cp0_wdata_i;
                // Only the software-interrupt bits of Cause are writable.
                CP0_CAUSE:  cause_eff_o[9:8] = wb_cp0_wdata_i[9:8];
                CP0_EPC:    epc_eff_o = wb_cp0_wdata_i;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception arbitration and pipeline redirect between MEM and CP0.
// Optional feature macro: EXC_TRAP_EN (enables mem_trap_i with ExcCode 13).
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic       clk,
    input logic       rst,
    exc_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    logic [31:0] status_eff, cause_eff, epc_eff;

    exc_fwd u_fwd (
        .wb_cp0_we_i    (bus.wb_cp0_we_i),
        .wb_cp0_waddr_i (bus.wb_cp0_waddr_i),
        .wb_cp0_wdata_i (bus.wb_cp0_wdata_i),
        .cp0_status_i   (bus.cp0_status_i),
        .cp0_cause_i    (bus.cp0_cause_i),
        .cp0_epc_i      (bus.cp0_epc_i),
        .status_eff_o   (status_eff),
        .cause_eff_o    (cause_eff),
        .epc_eff_o      (epc_eff)
    );

    logic unused_bits;
    assign unused_bits = ^{status_eff[31:16], status_eff[7:2],
                           cause_eff[31:16], cause_eff[7:0]};

    logic trap_hit;
`ifdef EXC_TRAP_EN
    assign trap_hit = bus.mem_trap_i;
`else
    logic unused_trap;
    assign unused_trap = bus.mem_trap_i;
    assign trap_hit    = 1'b0;
`endif

    logic irq_pending;
    assign irq_pending = (|(cause_eff[ST_IM_HI:ST_IM_LO] & status_eff[ST_IM_HI:ST_IM_LO]))
                         && status_eff[ST_IE] && !status_eff[ST_EXL];

    exc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush_q, flush_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic             exc_we_q, exc_we_d;
    logic             exc_eret_q, exc_eret_d;
    logic [4:0]       exc_code_q, exc_code_d;
    logic             exc_bd_q, exc_bd_d;
    logic [31:0]      exc_epc_q, exc_epc_d;

    logic       exc_hit;
    logic [4:0] exc_code_sel;

    always_comb begin
        exc_hit      = 1'b1;
        exc_code_sel = EXC_INT;
        if (irq_pending)            exc_code_sel = EXC_INT;
        else if (bus.mem_syscall_i) exc_code_sel = EXC_SYS;
        else if (bus.mem_ri_i)      exc_code_sel = EXC_RI;
        else if (trap_hit)          exc_code_sel = EXC_TR;
        else if (bus.mem_ov_i)      exc_code_sel = EXC_OV;
        else                        exc_hit      = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_d    = 1'b0;
        new_pc_d   = '0;
        exc_we_d   = 1'b0;
        exc_eret_d = 1'b0;
        exc_code_d = '0;
        exc_bd_d   = 1'b0;
        exc_epc_d  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.mem_valid_i && (exc_hit || bus.mem_eret_i)) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_LOAD;
                    flush_d = 1'b1;
                    if (exc_hit) begin
                        new_pc_d   = EXC_VECTOR;
                        exc_we_d   = 1'b1;
                        exc_code_d = exc_code_sel;
                        exc_bd_d   = bus.mem_in_delayslot_i;
                        exc_epc_d  = epc_of(bus.mem_pc_i, bus.mem_in_delayslot_i);
                    end else begin
                        new_pc_d   = epc_eff;
                        exc_eret_d = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            flush_q    <= 1'b0;
            new_pc_q   <= '0;
            exc_we_q   <= 1'b0;
            exc_eret_q <= 1'b0;
            exc_code_q <= '0;
            exc_bd_q   <= 1'b0;
            exc_epc_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            new_pc_q   <= new_pc_d;
            exc_we_q   <= exc_we_d;
            exc_eret_q <= exc_eret_d;
            exc_code_q <= exc_code_d;
            exc_bd_q   <= exc_bd_d;
            exc_epc_q  <= exc_epc_d;
        end
    end

    assign bus.flush_o    = flush_q;
    assign bus.new_pc_o   = new_pc_q;
    assign bus.busy_o     = (state_q == S_BUSY);
    assign bus.exc_we_o   = exc_we_q;
    assign bus.exc_eret_o = exc_eret_q;
    assign bus.exc_code_o = exc_code_q;
    assign bus.exc_bd_o   = exc_bd_q;
    assign bus.exc_epc_o  = exc_epc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomized and directed self-checking bench for exc_ctrl against a
// cycle-level behavioural model of the exception/redirect rules.
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'h0000_0020;
    localparam int          FC  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exc_ctrl_if bus ();

    exc_ctrl #(
        .EXC_VECTOR   (VEC),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state: busy cycles still to come, and expected outputs.
    int          rem = 0;
    logic        e_flush, e_we, e_eret, e_bd;
    logic [31:0] e_pc, e_epc;
    logic [4:0]  e_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.mem_valid_i        = 1'b0;
        bus.mem_pc_i           = '0;
        bus.mem_in_delayslot_i = 1'b0;
        bus.mem_syscall_i      = 1'b0;
        bus.mem_ri_i           = 1'b0;
        bus.mem_ov_i           = 1'b0;
        bus.mem_trap_i         = 1'b0;
        bus.mem_eret_i         = 1'b0;
        bus.cp0_status_i       = '0;
        bus.cp0_cause_i        = '0;
        bus.cp0_epc_i          = '0;
        bus.wb_cp0_we_i        = 1'b0;
        bus.wb_cp0_waddr_i     = '0;
        bus.wb_cp0_wdata_i     = '0;
    endtask

    // Decide what the coming edge should produce from the current inputs.
    task automatic model_edge();
        logic [31:0] st, ca, ep;
        logic        intr, trap_en;
        e_flush = 0; e_we = 0; e_eret = 0; e_bd = 0;
        e_pc = 0; e_epc = 0; e_code = 0;
`ifdef EXC_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        if (rem > 0) begin
            rem = rem - 1;
            return;
        end
        if (!bus.mem_valid_i) return;
        st = bus.cp0_status_i;
        ca = bus.cp0_cause_i;
        ep = bus.cp0_epc_i;
        if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd12) st = bus.wb_cp0_wdata_i;
        if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd13) ca[9:8] = bus.wb_cp0_wdata_i[9:8];
        if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd14) ep = bus.wb_cp0_wdata_i;
        intr = ((ca[15:8] & st[15:8]) != 8'h00) && st[0] && !st[1];
        e_we = 1;
        if (intr)                          e_code = 5'd0;
        else if (bus.mem_syscall_i)        e_code = 5'd8;
        else if (bus.mem_ri_i)             e_code = 5'd10;
        else if (trap_en && bus.mem_trap_i) e_code = 5'd13;
        else if (bus.mem_ov_i)             e_code = 5'd12;
        else                               e_we = 0;
        if (e_we) begin
            e_flush = 1;
            e_pc    = VEC;
            e_bd    = bus.mem_in_delayslot_i;
            e_epc   = bus.mem_in_delayslot_i ? bus.mem_pc_i + 32'hFFFF_FFFC : bus.mem_pc_i;
        end else if (bus.mem_eret_i) begin
            e_flush = 1;
            e_eret  = 1;
            e_pc    = ep;
        end
        if (e_flush) rem = FC;
    endtask

    task automatic compare(input string tag);
        chk({tag, ".flush"}, 32'(bus.flush_o), 32'(e_flush));
        chk({tag, ".busy"},  32'(bus.busy_o), 32'(rem > 0));
        chk({tag, ".we"},    32'(bus.exc_we_o), 32'(e_we));
        chk({tag, ".eret"},  32'(bus.exc_eret_o), 32'(e_eret));
        if (e_flush) chk({tag, ".new_pc"}, bus.new_pc_o, e_pc);
        if (e_we) begin
            chk({tag, ".code"}, 32'(bus.exc_code_o), 32'(e_code));
            chk({tag, ".bd"},   32'(bus.exc_bd_o), 32'(e_bd));
            chk({tag, ".epc"},  bus.exc_epc_o, e_epc);
        end
    endtask

    // Called at a negedge with inputs already driven; returns at next negedge.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare(tag);
        @(negedge clk);
    endtask

    task automatic settle();
        clear_inputs();
        for (int i = 0; i < FC + 1; i++) step("idle");
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".flush"},  32'(bus.flush_o), 32'd0);
        chk({tag, ".busy"},   32'(bus.busy_o), 32'd0);
        chk({tag, ".we"},     32'(bus.exc_we_o), 32'd0);
        chk({tag, ".eret"},   32'(bus.exc_eret_o), 32'd0);
        chk({tag, ".new_pc"}, bus.new_pc_o, 32'd0);
        chk({tag, ".code"},   32'(bus.exc_code_o), 32'd0);
        chk({tag, ".bd"},     32'(bus.exc_bd_o), 32'd0);
        chk({tag, ".epc"},    bus.exc_epc_o, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        step("post_reset");

        // Syscall, not in a delay slot.
        bus.mem_valid_i = 1; bus.mem_pc_i = 32'h100; bus.mem_syscall_i = 1;
        step("syscall");
        settle();

        // Overflow in a delay slot.
        bus.mem_valid_i = 1; bus.mem_pc_i = 32'h204; bus.mem_in_delayslot_i = 1; bus.mem_ov_i = 1;
        step("ov_ds");
        settle();

        // Interrupt enabled, then masked by EXL.
        bus.mem_valid_i = 1; bus.mem_pc_i = 32'h300;
        bus.cp0_status_i = 32'h1000_0401; bus.cp0_cause_i = 32'h0000_0400;
        step("irq");
        settle();
        bus.mem_valid_i = 1; bus.mem_pc_i = 32'h300;
        bus.cp0_status_i = 32'h1000_0403; bus.cp0_cause_i = 32'h0000_0400;
        step("irq_exl");
        settle();

        // ERET with EPC forwarded from WB.
        bus.mem_valid_i = 1; bus.mem_eret_i = 1; bus.cp0_epc_i = 32'h1234;
        bus.wb_cp0_we_i = 1; bus.wb_cp0_waddr_i = 5'd14; bus.wb_cp0_wdata_i = 32'h400;
        step("eret_fwd");
        settle();

        // Syscall then ri on the next two cycles: ri is dropped.
        bus.mem_valid_i = 1; bus.mem_pc_i = 32'h500; bus.mem_syscall_i = 1;
        step("busy_sys");
        bus.mem_syscall_i = 0; bus.mem_ri_i = 1; bus.mem_pc_i = 32'h504;
        step("busy_ri1");
        step("busy_ri2");
        settle();

        // PC 0 in a delay slot wraps the EPC.
        bus.mem_valid_i = 1; bus.mem_pc_i = 32'h0; bus.mem_in_delayslot_i = 1; bus.mem_ri_i = 1;
        step("pc_wrap");
        settle();

        // Reset asserted while BUSY.
        bus.mem_valid_i = 1; bus.mem_pc_i = 32'h600; bus.mem_syscall_i = 1;
        step("pre_rst");
        rst = 1'b0;
        #1;
        check_all_zero("rst_busy");
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        @(negedge clk);
        rst = 1'b1;
        rem = 0;
        clear_inputs();
        step("after_rst1");
        step("after_rst2");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bus.mem_valid_i        = ($urandom_range(0, 9) < 8);
            bus.mem_pc_i           = {$urandom(), 2'b00} >> 2 << 2;
            bus.mem_pc_i           = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) bus.mem_pc_i = 32'h0;
            bus.mem_in_delayslot_i = $urandom_range(0, 1);
            bus.mem_syscall_i      = ($urandom_range(0, 5) == 0);
            bus.mem_ri_i           = ($urandom_range(0, 5) == 0);
            bus.mem_ov_i           = ($urandom_range(0, 5) == 0);
            bus.mem_trap_i         = ($urandom_range(0, 5) == 0);
            bus.mem_eret_i         = ($urandom_range(0, 4) == 0);
            bus.cp0_status_i       = $urandom();
            bus.cp0_cause_i        = $urandom();
            if ($urandom_range(0, 1) == 0) bus.cp0_cause_i[15:8] = 8'h00;
            bus.cp0_epc_i          = $urandom();
            bus.wb_cp0_we_i        = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: bus.wb_cp0_waddr_i = 5'd12;
                1: bus.wb_cp0_waddr_i = 5'd13;
                2: bus.wb_cp0_waddr_i = 5'd14;
                default: bus.wb_cp0_waddr_i = 5'($urandom_range(0, 31));
            endcase
            bus.wb_cp0_wdata_i     = $urandom();
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
